// File: rtl/ili9341_frame_scheduler_if.sv
// Frame-scheduler bus: requester side (req/pixels), display-controller side
// (pixel handshake) and the status outputs, grouped for the scheduler port.
interface ili9341_frame_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int PIXEL_SIZE = 16
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*PIXEL_SIZE-1:0] req_pixel;
  logic                          pix_ready;
  logic [PIXEL_SIZE-1:0]         pix_data;
  logic                          pix_valid;
  logic [NUM_REQ-1:0]            grant;
  logic                          frame_done;
  logic [7:0]                    frame_count;

  modport master (
    output req, req_pixel, pix_ready,
    input  pix_data, pix_valid, grant, frame_done, frame_count
  );

  modport slave (
    input  req, req_pixel, pix_ready,
    output pix_data, pix_valid, grant, frame_done, frame_count
  );
endinterface

// File: rtl/ili9341_frame_scheduler.sv
// Round-robin frame scheduler: grants one requester a whole frame of
// RESOLUTION pixels to the ILI9341 controller, then rotates priority.
module ili9341_frame_scheduler #(
  parameter int RESOLUTION = 100,
  parameter int PIXEL_SIZE = 16,
  parameter int NUM_REQ    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  ili9341_frame_scheduler_if.slave bus
);
  localparam int CW = (RESOLUTION > 1) ? $clog2(RESOLUTION) : 1;
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [CW-1:0] LAST = CW'(RESOLUTION - 1);
  localparam logic [IW-1:0] TOP  = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [IW-1:0]         win_q, win_d, ptr_q, ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            fcnt_q, fcnt_d;
  logic [PIXEL_SIZE-1:0] pix_q, pix_d, src_pix;
  logic                  valid_q, done_q;
  logic [IW-1:0]         scan_idx, arb_idx;
  logic                  arb_found;

  // Search upward from ptr with wrap; first active requester wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!arb_found && bus.req[scan_idx]) begin
        arb_found = 1'b1;
        arb_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = STREAM;
          win_d   = arb_idx;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;
        end
      end
      STREAM: begin
        if (bus.pix_ready) begin
          if (cnt_q == LAST) begin
            // Count and pointer move on entry so DONE already shows them.
            state_d = DONE;
            cnt_d   = '0;
            grant_d = '0;
            fcnt_d  = fcnt_q + 8'd1;
            ptr_d   = (win_q == TOP) ? '0 : win_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    src_pix = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_d == IW'(i)) src_pix = bus.req_pixel[i*PIXEL_SIZE +: PIXEL_SIZE];
    end
    pix_d = (state_d == STREAM) ? src_pix : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      pix_q   <= pix_d;
      valid_q <= (state_d == STREAM);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.pix_data    = pix_q;
  assign bus.pix_valid   = valid_q;
  assign bus.grant       = grant_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_count = fcnt_q;
endmodule

// File: tb/tb_ili9341_frame_scheduler.sv
// Scoreboard bench for the frame scheduler: directed scenarios push expected
// pixels/frames, a negedge monitor pops and compares on every accept/done.
module tb_ili9341_frame_scheduler;
  localparam int NR  = 4;
  localparam int PS  = 16;
  localparam int RES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ili9341_frame_scheduler_if #(.NUM_REQ(NR), .PIXEL_SIZE(PS)) bus();

  ili9341_frame_scheduler #(.RESOLUTION(RES), .PIXEL_SIZE(PS), .NUM_REQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [NR-1:0] grant;
    logic [PS-1:0] data;
  } pix_t;

  pix_t       exp_pix[$];
  logic [7:0] exp_frm[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT accepts a pixel or ends a frame.
  always @(negedge clk) begin
    pix_t       e;
    logic [7:0] f;
    if (rst) begin
      chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
      if (!bus.pix_valid) chk("pix_data_zero_when_invalid", 32'(bus.pix_data), 32'd0);
      if (bus.pix_valid && bus.pix_ready) begin
        if (exp_pix.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_pixel: got grant %b data %h, expected none", bus.grant, bus.pix_data);
        end else begin
          e = exp_pix.pop_front();
          chk("pix_grant", 32'(bus.grant), 32'(e.grant));
          chk("pix_data", 32'(bus.pix_data), 32'(e.data));
        end
      end
      if (bus.frame_done) begin
        if (exp_frm.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_frame_done: got count %0d, expected no frame", bus.frame_count);
        end else begin
          f = exp_frm.pop_front();
          chk("frame_count", 32'(bus.frame_count), 32'(f));
          chk("done_grant", 32'(bus.grant), 32'd0);
          chk("done_valid", 32'(bus.pix_valid), 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_pix(input int i, input logic [PS-1:0] v);
    bus.req_pixel[i*PS +: PS] = v;
  endtask

  task automatic push_pix(input logic [NR-1:0] g, input logic [PS-1:0] d, input int n);
    pix_t e;
    e.grant = g;
    e.data  = d;
    repeat (n) exp_pix.push_back(e);
  endtask

  task automatic wait_done(input int n, input int budget);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < budget) begin
      tick();
      cyc++;
      if (bus.frame_done) seen++;
    end
    if (seen < n) begin
      n_chk++; n_fail++;
      $display("FAIL wait_done: got %0d frames, expected %0d within %0d cycles", seen, n, budget);
    end
  endtask

  task automatic drained(input string name);
    repeat (3) tick();
    chk(name, 32'(exp_pix.size() + exp_frm.size()), 32'd0);
    exp_pix.delete();
    exp_frm.delete();
  endtask

  task automatic do_reset();
    bus.req       = '0;
    bus.pix_ready = 1'b0;
    bus.req_pixel = '0;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  initial begin
    int k, strobes, done_seen;
    bus.req       = '0;
    bus.req_pixel = '0;
    bus.pix_ready = 1'b0;

    // Reset state
    #1 rst = 1'b0;
    #1;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_valid", 32'(bus.pix_valid), 32'd0);
    chk("rst_data", 32'(bus.pix_data), 32'd0);
    chk("rst_done", 32'(bus.frame_done), 32'd0);
    chk("rst_count", 32'(bus.frame_count), 32'd0);
    tick(); tick();
    rst = 1'b1;

    // Single request from requester 1
    push_pix(4'b0010, 16'hF800, 4);
    exp_frm.push_back(8'd1);
    set_pix(1, 16'hF800);
    set_pix(0, 16'h5555);
    bus.pix_ready = 1'b1;
    bus.req = 4'b0010;
    wait_done(1, 20);
    bus.req = '0;
    drained("single_drained");

    // Round robin with every requester active
    do_reset();
    for (int i = 0; i < NR; i++) set_pix(i, 16'(16'h1111 * (i + 1)));
    push_pix(4'b0001, 16'h1111, 4);
    push_pix(4'b0010, 16'h2222, 4);
    push_pix(4'b0100, 16'h3333, 4);
    push_pix(4'b1000, 16'h4444, 4);
    push_pix(4'b0001, 16'h1111, 4);
    for (int i = 1; i <= 5; i++) exp_frm.push_back(8'(i));
    bus.pix_ready = 1'b1;
    bus.req = 4'b1111;
    wait_done(5, 60);
    bus.req = '0;
    drained("rr_drained");

    // Backpressure: strobe every 3rd stream cycle, pixel changes every cycle
    do_reset();
    for (int j = 1; j <= 4; j++) push_pix(4'b0001, 16'(16'h0100 + 3*j - 1), 1);
    exp_frm.push_back(8'd1);
    set_pix(0, 16'h0100);
    bus.req = 4'b0001;
    k = 0; strobes = 0; done_seen = 0;
    for (int c = 0; c < 60 && done_seen == 0; c++) begin
      tick();
      if (bus.frame_done) done_seen = 1;
      else if (bus.pix_valid) begin
        k++;
        set_pix(0, 16'(16'h0100 + k));
        bus.pix_ready = (k % 3 == 0);
        if (bus.pix_ready) strobes++;
      end else bus.pix_ready = 1'b0;
    end
    bus.req = '0;
    bus.pix_ready = 1'b0;
    chk("bp_done_seen", 32'(done_seen), 32'd1);
    chk("bp_stream_cycles", 32'(k), 32'd12);
    chk("bp_strobes", 32'(strobes), 32'd4);
    drained("bp_drained");

    // Idle with pix_ready, then requester drop plus a late competing request
    do_reset();
    bus.pix_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_grant", 32'(bus.grant), 32'd0);
      chk("idle_valid", 32'(bus.pix_valid), 32'd0);
    end
    set_pix(2, 16'h001F);
    set_pix(0, 16'hAAAA);
    push_pix(4'b0100, 16'h001F, 4);
    push_pix(4'b0001, 16'hAAAA, 4);
    exp_frm.push_back(8'd1);
    exp_frm.push_back(8'd2);
    bus.req = 4'b0100;
    tick(); tick();
    bus.req = 4'b0001;
    wait_done(2, 30);
    bus.req = '0;
    drained("drop_drained");

    // Reset mid-frame after two pixels
    do_reset();
    set_pix(0, 16'h1234);
    push_pix(4'b0001, 16'h1234, 2);
    bus.pix_ready = 1'b1;
    bus.req = 4'b0001;
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    chk("midrst_grant", 32'(bus.grant), 32'd0);
    chk("midrst_valid", 32'(bus.pix_valid), 32'd0);
    chk("midrst_data", 32'(bus.pix_data), 32'd0);
    chk("midrst_done", 32'(bus.frame_done), 32'd0);
    chk("midrst_count", 32'(bus.frame_count), 32'd0);
    chk("midrst_partial", 32'(exp_pix.size()), 32'd0);
    tick();
    push_pix(4'b0001, 16'h1234, 4);
    exp_frm.push_back(8'd1);
    rst = 1'b1;
    wait_done(1, 20);
    bus.req = '0;
    drained("midrst_drained");

    // Frame counter wrap after 256 frames
    do_reset();
    set_pix(0, 16'hBEEF);
    push_pix(4'b0001, 16'hBEEF, 4 * 256);
    for (int i = 1; i <= 256; i++) exp_frm.push_back(8'(i));
    bus.pix_ready = 1'b1;
    bus.req = 4'b0001;
    wait_done(256, 256 * 6 + 50);
    bus.req = '0;
    tick();
    chk("wrap_count", 32'(bus.frame_count), 32'd0);
    drained("wrap_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ili9341_frame_scheduler.md
ILI9341_FRAME_SCHEDULER -- requirements
Module: ili9341_frame_scheduler

Interface
REQ-001 The block SHALL have parameter RESOLUTION, default 100, giving the pixels per frame.
REQ-002 The block SHALL have parameter PIXEL_SIZE, default 16, giving the RGB565 pixel width.
REQ-003 The block SHALL have parameter NUM_REQ, default 4, giving the number of image-source requesters (2..8).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: per-requester frame request, level-sensitive.
REQ-007 The block SHALL have port req_pixel, input, NUM_REQ*PIXEL_SIZE bits: requester i's pixel occupies bits [i*PIXEL_SIZE +: PIXEL_SIZE].
REQ-008 The block SHALL have port pix_ready, input, 1 bit: a single-cycle strobe from the display controller meaning the current pixel is accepted.
REQ-009 The block SHALL have port pix_data, output, PIXEL_SIZE bits: the pixel presented to the controller.
REQ-010 The block SHALL have port pix_valid, output, 1 bit: pix_data is valid.
REQ-011 The block SHALL have port grant, output, NUM_REQ bits: the one-hot owner of the current frame.
REQ-012 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse after the last pixel of a frame is accepted.
REQ-013 The block SHALL have port frame_count, output, 8 bits: the count of completed frames, which wraps.

Function
REQ-014 The block SHALL implement FSM states IDLE, STREAM and DONE, all registered.
REQ-015 In IDLE with req==0, the block SHALL remain in IDLE with grant=0 and pix_valid=0.
REQ-016 In IDLE with any req bit set, the block SHALL, on the next edge, load grant with the round-robin winner and enter STREAM.
REQ-017 For round-robin arbitration, the block SHALL search from index ptr upward with wrap-around; ptr is 0 after reset and is set to (winner+1) mod NUM_REQ in DONE.
REQ-018 In STREAM, the block SHALL hold pix_valid=1 and register pix_data from the granted slice every cycle, giving 1-cycle latency from req_pixel to pix_data.
REQ-019 The block SHALL ignore pix_ready outside STREAM.
REQ-020 In STREAM, each pix_ready SHALL increment pixel_cnt, of width $clog2(RESOLUTION).
REQ-021 When pix_ready arrives while pixel_cnt==RESOLUTION-1, the block SHALL clear pixel_cnt and enter DONE.
REQ-022 Deasserting req during STREAM SHALL NOT abort the frame: grant and sourcing are held until the frame completes.
REQ-023 A new req from another requester during STREAM SHALL NOT preempt the current frame.
REQ-024 DONE SHALL last exactly one cycle, with frame_done=1, pix_valid=0, grant=0, pix_data=0 and frame_count incremented mod 256; the next state is IDLE.
REQ-025 A request held continuously SHALL be re-served only after every other active requester has received one frame, so no requester starves.
REQ-026 When not in STREAM, pix_data SHALL be 0.
REQ-027 grant SHALL be one-hot or zero in every cycle.

Reset
REQ-028 rst low SHALL immediately force: state IDLE, grant=0, pix_valid=0, pix_data=0, frame_done=0, frame_count=0, pixel_cnt=0, ptr=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release, the first frame starts again at pixel 0 with ptr=0.
REQ-030 Release of rst SHALL be synchronous to clk; the first arbitration occurs on the first edge after release.

Verification (RESOLUTION=4, NUM_REQ=4, PIXEL_SIZE=16)
REQ-031 The bench SHALL check a single request: req=0010 with req_pixel[1]=F800 and pix_ready every cycle -> grant=0010, four pixels F800 accepted, frame_done one pulse, frame_count=1.
REQ-032 The bench SHALL check round-robin: req=1111 held -> grant order 0001, 0010, 0100, 1000, 0001, with frame_count reaching 5.
REQ-033 The bench SHALL check backpressure: pix_ready strobed every 3rd cycle -> the frame takes 12 STREAM cycles, pix_valid held high, and frame_done pulses after the 4th strobe.
REQ-034 The bench SHALL check requester drop: req 0100 deasserted after the 1st pixel -> all 4 pixels are still sourced from requester 2 and grant holds 0100 until DONE.
REQ-035 The bench SHALL check reset mid-frame: rst low after 2 pixels -> all outputs are 0 immediately; after release with req=0001, a full 4-pixel frame completes and frame_count=1.
REQ-036 The bench SHALL check counter wrap: 256 completed frames -> frame_count returns to 0.
